bicubic_nx_simd_mac4: RTL
=========================

// Module: bicubic_nx_simd_mac4
// PURPOSE
//  N-lane 4-tap bicubic multiply-accumulate with a valid/ready stream interface.
//  Each lane computes y = clamp(round((p0*c0 + p1*c1 + p2*c2 + p3*c3) >> FRAC_BITS)).
//  Sits between the line-buffer tap extractor and the pixel packer.
//  Generalises the fixed 2-tap INT9xUINT8 SIMD multiplier: widths, fraction and lane count are
//  parametrised; adds in-block rounding/saturation, a bypass mode, backpressure and a clip counter.
// PARAMETERS
//  PARALLEL_CORE  8   number of independent lanes
//  PIX_W          8   unsigned pixel width (taps and output)
//  COEF_W         9   signed two's-complement coefficient width
//  FRAC_BITS      7   coefficient fraction bits (1.0 == 1<<FRAC_BITS); legal range 0..COEF_W-1
//  CNT_W          16  clip counter width
// PORTS
//  clk        in   1                      clock, all logic rising-edge
//  reset      in   1                      synchronous, active-high
//  clken      in   1                      global clock enable; 0 freezes all state incl. counter
//  in_valid   in   1                      input beat valid
//  in_ready   out  1                      input beat accepted when in_valid & in_ready
//  in_bypass  in   1                      beat-wide: 1 -> output p1 unmodified (integer phase)
//  pix        in   PARALLEL_CORE*4*PIX_W  lane i, tap k at [(i*4+k)*PIX_W +: PIX_W]
//  coeff      in   4*COEF_W               shared signed taps c0..c3, tap k at [k*COEF_W +: COEF_W]
//  out_valid  out  1                      output beat valid
//  out_ready  in   1                      downstream accepts when out_valid & out_ready
//  dout       out  PARALLEL_CORE*PIX_W    lane i at [i*PIX_W +: PIX_W]
//  cnt_clear  in   1                      synchronous clear of clip_cnt
//  clip_cnt   out  CNT_W                  saturating count of lane results clamped at the output
// BEHAVIOUR
//  - Reset: out_valid=0, dout=0, clip_cnt=0, every stage valid=0; in_ready=1 on the first
//    cycle after reset deasserts. Reset mid-stream discards all in-flight beats.
//  - Pipeline: 4 stages, S1 input reg -> S2 products -> S3 pair sums -> S4 sum/round/clamp -> dout.
//    advance = clken & (~out_valid | out_ready); in_ready = advance (combinational).
//  - No stall: a beat accepted at edge t has out_valid=1 and dout valid after edge t+4; throughput 1 beat/clk.
//  - Stall: out_valid & ~out_ready freezes every stage; dout is held stable and no beat is dropped or duplicated.
//  - Bubbles: a stage valid bit propagates with its data; empty slots never raise out_valid.
//  - Arithmetic per lane: product = $signed({1'b0,p}) * $signed(c), width PIX_W+COEF_W+1.
//    Sum width PIX_W+COEF_W+3 (no internal overflow possible).
//    If FRAC_BITS>0, add 1<<(FRAC_BITS-1); then arithmetic shift right by FRAC_BITS (round half up).
//    Clamp: <0 -> 0; >2^PIX_W-1 -> 2^PIX_W-1.
//  - Bypass: dout lane = p1 with the same 4-cycle latency. coeff is ignored; no clips are counted.
//  - clip_cnt: at each output handshake, add the number of clamped lanes (0..PARALLEL_CORE);
//    saturates at 2^CNT_W-1. cnt_clear has priority over a same-cycle increment (result 0).
//  - in_bypass and coeff are sampled together with pix at acceptance and travel with the beat.
// TESTING
//  (PIX_W=8, COEF_W=9, FRAC_BITS=7, PARALLEL_CORE=8)
//  1 identity: pix lane0=(10,20,30,40), coeff=(0,128,0,0) -> lane0 dout=20, 4 clk after accept, clip_cnt=0
//  2 mixed sign: pix=(10,20,30,40), coeff=(-9,111,29,-3) -> sum 2880+64=2944, >>7 -> dout=23
//  3 saturation: pix=(0,255,255,0), coeff=(-16,160,0,0) -> 255, clip_cnt+1;
//    pix=(255,0,0,255), coeff=(-64,0,0,0) -> 0, clip_cnt+1
//  4 backpressure: stream 20 beats with incrementing p1, coeff=(0,128,0,0), random out_ready (~50%)
//    -> exactly 20 outputs in order, dout stable while stalled
//  5 bypass + clear: in_bypass=1, coeff=(-64,0,0,0), p1=77 -> dout=77, no clip counted;
//    cnt_clear with a same-cycle clip -> clip_cnt=0
//  6 reset mid-op: assert reset with 3 beats in flight -> out_valid=0 next clk; no stale beat
//    ever appears; the next new beat has latency 4

Source files
------------

// File: rtl/bicubic_nx_simd_mac4.sv
// bicubic_nx_simd_mac4: N-lane 4-tap bicubic MAC with rounding, clamping, bypass, backpressure and clip counter
module bicubic_nx_simd_mac4 #(
  parameter int PARALLEL_CORE = 8,
  parameter int PIX_W         = 8,
  parameter int COEF_W        = 9,
  parameter int FRAC_BITS     = 7,
  parameter int CNT_W         = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             clken,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic                             in_bypass,
  input  logic [PARALLEL_CORE*4*PIX_W-1:0] pix,
  input  logic [4*COEF_W-1:0]              coeff,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [PARALLEL_CORE*PIX_W-1:0]   dout,
  input  logic                             cnt_clear,
  output logic [CNT_W-1:0]                 clip_cnt
);
  localparam int N  = PARALLEL_CORE;
  localparam int PW = PIX_W + COEF_W + 1;
  localparam int SW = PIX_W + COEF_W + 3;
  localparam int NW = $clog2(N + 1);
  localparam logic signed [SW-1:0] RND = SW'((1 << FRAC_BITS) >> 1);
  logic advance;
  logic s1_v, s2_v, s3_v, s4_v;
  logic s1_byp, s2_byp, s3_byp, s4_byp;
  logic [N*4*PIX_W-1:0] s1_pix;
  logic [4*COEF_W-1:0] s1_coef;
  logic signed [PW-1:0] s2_prod [N][4];
  logic signed [SW-1:0] s3_sum [N][2];
  logic signed [SW-1:0] s4_val [N];
  logic [PIX_W-1:0] s2_p1 [N];
  logic [PIX_W-1:0] s3_p1 [N];
  logic [PIX_W-1:0] s4_p1 [N];
  logic [N*PIX_W-1:0] dout_nx;
  logic [NW-1:0] clip_nx, dout_clip;
  logic [CNT_W:0] cnt_sum;
  assign advance = clken & (~out_valid | out_ready);
  assign in_ready = advance;
  assign cnt_sum = {1'b0, clip_cnt} + (CNT_W+1)'(dout_clip);
  // stage valid bits, output register and saturating clip counter
  always_ff @(posedge clk)
    if (reset) begin
      {s1_v, s2_v, s3_v, s4_v, out_valid} <= '0;
      dout <= '0;
      dout_clip <= '0;
      clip_cnt <= '0;
    end else if (clken) begin
      if (advance) begin
        s1_v <= in_valid;
        s2_v <= s1_v;
        s3_v <= s2_v;
        s4_v <= s3_v;
        out_valid <= s4_v;
        dout <= dout_nx;
        dout_clip <= clip_nx;
      end
      if (cnt_clear) clip_cnt <= '0;
      else if (out_valid & out_ready) clip_cnt <= cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
    end
  // datapath: input capture, products, pair sums, rounded shift; bypass pixel rides alongside
  always_ff @(posedge clk)
    if (advance) begin
      s1_pix <= pix;
      s1_coef <= coeff;
      s1_byp <= in_bypass;
      s2_byp <= s1_byp;
      s3_byp <= s2_byp;
      s4_byp <= s3_byp;
      for (int i = 0; i < N; i++) begin
        for (int k = 0; k < 4; k++)
          s2_prod[i][k] <= PW'($signed({1'b0, s1_pix[(i*4+k)*PIX_W +: PIX_W]})) *
                           PW'($signed(s1_coef[k*COEF_W +: COEF_W]));
        s2_p1[i] <= s1_pix[(i*4+1)*PIX_W +: PIX_W];
        s3_sum[i][0] <= SW'(s2_prod[i][0]) + SW'(s2_prod[i][1]);
        s3_sum[i][1] <= SW'(s2_prod[i][2]) + SW'(s2_prod[i][3]);
        s3_p1[i] <= s2_p1[i];
        s4_val[i] <= (s3_sum[i][0] + s3_sum[i][1] + RND) >>> FRAC_BITS;
        s4_p1[i] <= s3_p1[i];
      end
    end
  // clamp to the pixel range (or pass p1 in bypass) and count clamped lanes
  always_comb begin
    dout_nx = '0;
    clip_nx = '0;
    for (int i = 0; i < N; i++) begin
      dout_nx[i*PIX_W +: PIX_W] = s4_byp ? s4_p1[i] :
                                  s4_val[i][SW-1] ? '0 :
                                  (|s4_val[i][SW-2:PIX_W]) ? '1 : s4_val[i][PIX_W-1:0];
      clip_nx = clip_nx + NW'(~s4_byp & (s4_val[i][SW-1] | (|s4_val[i][SW-2:PIX_W])));
    end
  end
endmodule
